// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - constants shared with the FFT stages and the bit-reversal helper
package fft_pkg;
  localparam int FFT_DATA_WIDTH = 25;
  localparam int FFT_N_LOG2     = 9;
  localparam int BITREV_MAX     = 16;

  // Reverses the low n_log2 bits of v; bits above n_log2 come back as zero.
  function automatic logic [BITREV_MAX-1:0] bitrev(input logic [BITREV_MAX-1:0] v,
                                                   input int n_log2);
    logic [BITREV_MAX-1:0] r;
    r = '0;
    for (int b = 0; b < BITREV_MAX; b++) begin
      if (b < n_log2) r[b] = v[n_log2-1-b];
    end
    return r;
  endfunction
endpackage

// File: rtl/fft_ram_sdp.sv
// rtl/fft_ram_sdp.sv - simple dual-port RAM, one write port and one registered read port
module fft_ram_sdp #(
  parameter int AW = 10,
  parameter int DW = 50
) (
  input  logic          clk_i,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk_i) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/fft_bitrev_buf.sv
// rtl/fft_bitrev_buf.sv - ping-pong bit-reverse to natural-order buffer for the FFT output
// FFT_BITREV_OVF_EN builds frame-overflow detection; otherwise ovf_o is tied low.
module fft_bitrev_buf
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = FFT_DATA_WIDTH,
  parameter int N_LOG2     = FFT_N_LOG2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         valid_i,
  input  logic signed [DATA_WIDTH-1:0] x_re_i,
  input  logic signed [DATA_WIDTH-1:0] x_im_i,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic signed [DATA_WIDTH-1:0] z_re_o,
  output logic signed [DATA_WIDTH-1:0] z_im_o,
  output logic [N_LOG2-1:0]            idx_o,
  output logic                         ovf_o
);
  typedef enum logic {RD_IDLE, RD_STREAM} rd_state_t;
  localparam logic [N_LOG2-1:0] LAST = '1;

  rd_state_t               rd_state;
  logic [N_LOG2-1:0]       wr_cnt, rd_addr, s1_idx, wr_addr_lo;
  logic                    wr_bank, rd_bank, s1_valid;
  logic [1:0]              full;
  logic [2*DATA_WIDTH-1:0] rd_data;
  logic                    adv, issue, rd_last, wr_done, wr_en, wr_accept;

  // The read pipeline (RAM register, output register) stalls as one unit.
  assign adv     = !valid_o || ready_i;
  assign issue   = (rd_state == RD_STREAM) && adv;
  assign rd_last = issue && (rd_addr == LAST);
  assign wr_done = valid_i && (wr_cnt == LAST);
  assign wr_addr_lo = N_LOG2'(bitrev(BITREV_MAX'(wr_cnt), N_LOG2));

`ifdef FFT_BITREV_OVF_EN
  logic wr_blocked, frame_drop, ovf_q;

  // The target bank is still owned by the reader unless it is released on this edge.
  assign wr_blocked = full[wr_bank] && !(rd_last && (rd_bank == wr_bank));
  assign wr_en      = valid_i && !wr_blocked;
  assign wr_accept  = wr_done && !wr_blocked && !frame_drop;
  assign ovf_o      = ovf_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      frame_drop <= 1'b0;
      ovf_q      <= 1'b0;
    end else if (valid_i) begin
      if (wr_done) begin
        frame_drop <= 1'b0;
        if (!wr_accept) ovf_q <= 1'b1;
      end else if (wr_blocked) begin
        frame_drop <= 1'b1;
      end
    end
  end
`else
  assign wr_en     = valid_i;
  assign wr_accept = wr_done;
  assign ovf_o     = 1'b0;
`endif

  fft_ram_sdp #(.AW(N_LOG2 + 1), .DW(2 * DATA_WIDTH)) u_ram (
    .clk_i (clk_i),
    .we    (wr_en),
    .waddr ({wr_bank, wr_addr_lo}),
    .wdata ({x_re_i, x_im_i}),
    .re    (issue),
    .raddr ({rd_bank, rd_addr}),
    .rdata (rd_data)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_cnt   <= '0;
      wr_bank  <= 1'b0;
      full     <= 2'b00;
      rd_state <= RD_IDLE;
      rd_bank  <= 1'b0;
      rd_addr  <= '0;
      s1_valid <= 1'b0;
      s1_idx   <= '0;
      valid_o  <= 1'b0;
      z_re_o   <= '0;
      z_im_o   <= '0;
      idx_o    <= '0;
    end else begin
      if (valid_i) wr_cnt <= wr_cnt + 1'b1;
      if (rd_last) full[rd_bank] <= 1'b0;
      if (wr_accept) begin
        full[wr_bank] <= 1'b1;
        wr_bank       <= !wr_bank;
      end

      case (rd_state)
        RD_IDLE: begin
          if (wr_accept) begin
            rd_state <= RD_STREAM;
            rd_bank  <= wr_bank;
            rd_addr  <= '0;
          end
        end
        RD_STREAM: begin
          if (issue) begin
            rd_addr <= rd_addr + 1'b1;
            // A bank that is full, or completes on this very edge, follows with no bubble.
            if (rd_last) begin
              if (full[!rd_bank] || (wr_accept && (wr_bank != rd_bank))) rd_bank <= !rd_bank;
              else rd_state <= RD_IDLE;
            end
          end
        end
      endcase

      if (adv) begin
        s1_valid <= issue;
        s1_idx   <= rd_addr;
        valid_o  <= s1_valid;
        if (s1_valid) begin
          idx_o  <= s1_idx;
          z_re_o <= rd_data[2*DATA_WIDTH-1:DATA_WIDTH];
          z_im_o <= rd_data[DATA_WIDTH-1:0];
        end
      end
    end
  end
endmodule

// File: tb/tb_fft_bitrev_buf.sv
// tb/tb_fft_bitrev_buf.sv - directed bench for fft_bitrev_buf, N_LOG2=4, DATA_WIDTH=25
// Define FFT_BITREV_OVF_EN for both bench and RTL to cover the overflow case.
`timescale 1ns/1ps
module tb_fft_bitrev_buf;
  localparam int DW = 25;
  localparam int NL = 4;
  localparam int N  = 16;

  logic                 clk_i = 1'b0;
  logic                 rst_i, valid_i, ready_i, valid_o, ovf_o;
  logic signed [DW-1:0] x_re_i, x_im_i, z_re_o, z_im_o;
  logic [NL-1:0]        idx_o;

  int checks = 0;
  int failures = 0;
  logic signed [DW-1:0] exp_re[$];
  logic signed [DW-1:0] exp_im[$];
  int                   exp_idx[$];

  fft_bitrev_buf #(.DATA_WIDTH(DW), .N_LOG2(NL)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (valid_i),
    .x_re_i  (x_re_i),
    .x_im_i  (x_im_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .z_re_o  (z_re_o),
    .z_im_o  (z_im_o),
    .idx_o   (idx_o),
    .ovf_o   (ovf_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic int br4(input int j);
    return ((j & 1) << 3) | ((j & 2) << 1) | ((j & 4) >> 1) | ((j & 8) >> 3);
  endfunction

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Input sample j carries re = bitrev4(j)+base, im = -j-base.
  task automatic drive_frame(input int base, input bit gapped);
    for (int j = 0; j < N; j++) begin
      valid_i = 1'b1;
      x_re_i  = DW'(br4(j) + base);
      x_im_i  = DW'(-j - base);
      @(posedge clk_i); #1;
      if (gapped) begin
        valid_i = 1'b0;
        x_re_i  = DW'(12345);
        x_im_i  = DW'(-777);
        @(posedge clk_i); #1;
      end
    end
    valid_i = 1'b0;
  endtask

  // Natural-order bin i therefore holds re = i+base, im = -bitrev4(i)-base.
  task automatic expect_frame(input int base);
    for (int i = 0; i < N; i++) begin
      exp_re.push_back(DW'(i + base));
      exp_im.push_back(DW'(-br4(i) - base));
      exp_idx.push_back(i);
    end
  endtask

  task automatic check_stream(input int n, input int budget, output int first_cyc, output int gaps);
    int got;
    int cyc;
    got = 0;
    cyc = 0;
    first_cyc = -1;
    gaps = 0;
    while (got < n && cyc < budget) begin
      @(negedge clk_i);
      if (valid_o === 1'b1) begin
        if (first_cyc < 0) first_cyc = cyc;
        chk("z_re", z_re_o, exp_re[0]);
        chk("z_im", z_im_o, exp_im[0]);
        chk("idx", idx_o, exp_idx[0]);
        if (ready_i) begin
          void'(exp_re.pop_front());
          void'(exp_im.pop_front());
          void'(exp_idx.pop_front());
          got++;
        end
      end else if (first_cyc >= 0) begin
        gaps++;
      end
      cyc++;
    end
    chk("stream_count", got, n);
  endtask

  task automatic check_quiet(input string tag, input int cycles);
    repeat (cycles) begin
      @(negedge clk_i);
      chk(tag, valid_o, 0);
    end
  endtask

  initial begin
    int fc;
    int gp;
    bit found;

    // Reset with live input: every output must read zero.
    rst_i = 1'b1; valid_i = 1'b1; ready_i = 1'b1;
    x_re_i = DW'(77); x_im_i = DW'(-5);
    repeat (3) begin
      @(negedge clk_i);
      chk("rst_valid", valid_o, 0);
      chk("rst_z_re", z_re_o, 0);
      chk("rst_z_im", z_im_o, 0);
      chk("rst_idx", idx_o, 0);
      chk("rst_ovf", ovf_o, 0);
    end
    @(posedge clk_i); #1;
    rst_i = 1'b0; valid_i = 1'b0;

    // Single frame: output starts two edges after the last accepted sample.
    expect_frame(0);
    drive_frame(0, 1'b0);
    @(negedge clk_i); chk("lat_edge_k", valid_o, 0);
    @(negedge clk_i); chk("lat_edge_k1", valid_o, 0);
    check_stream(N, 40, fc, gp);
    chk("single_first_cycle", fc, 0);
    chk("single_contig", gp, 0);
    check_quiet("single_quiet", 4);

    // Back-to-back frames: 32 contiguous outputs across the bank swap.
    @(posedge clk_i); #1;
    expect_frame(0);
    expect_frame(100);
    fork
      begin
        drive_frame(0, 1'b0);
        drive_frame(100, 1'b0);
      end
      check_stream(2 * N, 100, fc, gp);
    join
    chk("b2b_contig", gp, 0);
    check_quiet("b2b_quiet", 4);

    // Gapped input plus a five-cycle stall while idx 6 is presented.
    @(posedge clk_i); #1;
    expect_frame(40);
    found = 1'b0;
    fork
      drive_frame(40, 1'b1);
      check_stream(N, 200, fc, gp);
      begin
        for (int c = 0; c < 200 && !found; c++) begin
          @(posedge clk_i); #1;
          if (valid_o && idx_o == 6) begin
            found = 1'b1;
            ready_i = 1'b0;
            repeat (5) begin @(posedge clk_i); #1; end
            ready_i = 1'b1;
          end
        end
      end
    join
    chk("bp_stall_seen", found, 1);
    chk("bp_contig", gp, 0);
    check_quiet("bp_quiet", 4);

    // Reset after 7 samples: the partial frame must vanish.
    @(posedge clk_i); #1;
    for (int j = 0; j < 7; j++) begin
      valid_i = 1'b1;
      x_re_i = DW'(br4(j) + 500);
      x_im_i = DW'(-j - 500);
      @(posedge clk_i); #1;
    end
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0; valid_i = 1'b0;
    chk("midrst_valid", valid_o, 0);
    expect_frame(200);
    drive_frame(200, 1'b0);
    check_stream(N, 40, fc, gp);
    chk("midrst_first_cycle", fc, 2);
    chk("midrst_contig", gp, 0);
    check_quiet("midrst_quiet", 6);

`ifdef FFT_BITREV_OVF_EN
    // Three frames with downstream stalled: the third overflows and is dropped.
    @(posedge clk_i); #1;
    ready_i = 1'b0;
    expect_frame(300);
    expect_frame(400);
    drive_frame(300, 1'b0);
    drive_frame(400, 1'b0);
    @(negedge clk_i); chk("ovf_before_f3", ovf_o, 0);
    @(posedge clk_i); #1;
    drive_frame(500, 1'b0);
    @(negedge clk_i); chk("ovf_after_f3", ovf_o, 1);
    @(posedge clk_i); #1;
    ready_i = 1'b1;
    check_stream(2 * N, 100, fc, gp);
    chk("ovf_first_cycle", fc, 0);
    chk("ovf_contig", gp, 0);
    check_quiet("ovf_quiet", 4);
    chk("ovf_sticky", ovf_o, 1);
`else
    chk("ovf_tied_low", ovf_o, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
